grant_tenure_sequencer: RTL and testbench
=========================================

// Module: grant_tenure_sequencer
// PURPOSE
//   Downstream stage of the priority arbiter. Accepts the arbiter's valid/grant pair.
//   Locks the winning channel and holds its one-hot grant for a bounded tenure.
//   Releases early if the owner drops its request, then inserts a one-cycle gap so the
//   arbiter can re-evaluate. Keeps a per-channel saturating service count for the display.
// PARAMETERS
//   N            8   number of requesters
//   W            $clog2(N)   grant index width
//   HOLD_CYCLES  16  maximum tenure in cycles; legal range is >= 1
//   CW           8   width of each per-channel service counter
// PORTS
//   clk         in   1     system clock, all state on rising edge
//   rst         in   1     asynchronous, active-high reset
//   req         in   N     debounced request vector, same one fed to the arbiter
//   valid       in   1     arbiter has a winner
//   grant       in   W     arbiter winner index
//   gnt_onehot  out  N     one-hot grant to the current owner, 0 when no owner
//   owner       out  W     index of the locked owner, holds its last value when idle
//   busy        out  1     high in SERVE and RELEASE
//   done        out  1     one-cycle pulse, high in the RELEASE cycle
//   done_id     out  W     channel that finished, valid while done=1
//   early       out  1     valid with done; 1 = tenure cut short by request drop
//   svc_count   out  N*CW  flat array; channel i occupies bits [i*CW +: CW]
// BEHAVIOUR
//   Reset (async, on rst=1):
//     - state goes to IDLE; tenure counter is 0.
//     - gnt_onehot, owner, busy, done, done_id, early and all svc_count fields are 0.
//   Release of reset: a synchronised deassert is NOT done here; the top level provides it.
//   Every output is registered; there are no combinational paths from input to output.
//   FSM IDLE:
//     - If valid && grant<N && req[grant]: latch owner<=grant, tenure counter <=0, go to SERVE.
//     - The grant is visible one cycle after sampling.
//     - valid with grant>=N, or with req[grant]=0, is ignored; the FSM stays in IDLE.
//   FSM SERVE:
//     - gnt_onehot = 1<<owner; busy=1.
//     - Each cycle, if req[owner]=0: go to RELEASE with early<=1.
//     - Else if counter==HOLD_CYCLES-1: go to RELEASE with early<=0.
//     - Else counter++.
//     - A full tenure gives exactly HOLD_CYCLES cycles with gnt_onehot high.
//     - Request drop wins over expiry when both happen in the same cycle (early=1).
//     - Changes on valid/grant during SERVE are ignored; there is no preemption.
//   FSM RELEASE (1 cycle):
//     - gnt_onehot=0, busy=1, done=1, done_id=owner.
//     - svc_count[owner] increments, saturating at 2^CW-1; the new value shows next cycle.
//     - Always returns to IDLE. Back-to-back grants are therefore spaced by at least 1 idle cycle.
//   Counter width is $clog2(HOLD_CYCLES+1); it never wraps.
//   HOLD_CYCLES=1: SERVE lasts exactly one cycle.
//   Reset mid-tenure: the grant drops immediately; no done pulse; counts are cleared.
//   done, early and done_id are 0 outside RELEASE.
//   Invariants:
//     - gnt_onehot is zero or has exactly one bit set.
//     - If gnt_onehot!=0, then busy=1.
// TESTING
//   1. Reset, then req=8'h04, valid=1, grant=2 held.
//      -> gnt_onehot=8'h04 for 16 cycles, then done=1, done_id=2, early=0.
//      -> svc_count[2]=1; next grant no earlier than 2 cycles after done.
//   2. req=8'h20, grant=5; drop req[5] on the 4th SERVE cycle.
//      -> grant high for exactly 4 cycles, then done=1, early=1, svc_count[5]=1.
//   3. During SERVE of ch3, switch grant to 6 with req=8'h48.
//      -> ch3 keeps its grant until tenure end; ch6 is granted next.
//   4. valid=1 with grant=4 and req[4]=0 -> FSM stays IDLE, gnt_onehot=0, busy=0.
//   5. CW=2: serve ch0 five times -> svc_count[0] reads 1,2,3,3,3.
//   6. Assert rst in the 7th cycle of a tenure.
//      -> all outputs 0 immediately (same cycle, async).
//      -> after release, a new valid/grant is accepted normally.

Source files
------------

// File: rtl/grant_tenure_sequencer_if.sv
// ---------------------------------------------------------------------------
// grant_tenure_sequencer_if
//   Bundles the arbiter-facing handshake and the status outputs of the
//   grant tenure sequencer.
//
//   Signals
//     req         N     request vector, same one fed to the arbiter
//     valid       1     arbiter has a winner
//     grant       W     arbiter winner index
//     gnt_onehot  N     one-hot grant to the current owner
//     owner       W     index of the locked owner
//     busy        1     sequencer is serving or releasing
//     done        1     single-cycle pulse at the end of a tenure
//     done_id     W     channel that just finished
//     early       1     tenure was cut short by a request drop
//     svc_count   N*CW  flat per-channel saturating service counts
//
//   Modports
//     master  drives req/valid/grant, observes the status outputs
//     slave   the sequencer itself
// ---------------------------------------------------------------------------
interface grant_tenure_sequencer_if #(
    parameter int N  = 8,
    parameter int W  = (N > 1) ? $clog2(N) : 1,
    parameter int CW = 8
);
    logic [N-1:0]    req;
    logic            valid;
    logic [W-1:0]    grant;
    logic [N-1:0]    gnt_onehot;
    logic [W-1:0]    owner;
    logic            busy;
    logic            done;
    logic [W-1:0]    done_id;
    logic            early;
    logic [N*CW-1:0] svc_count;

    modport master (
        output req,
        output valid,
        output grant,
        input  gnt_onehot,
        input  owner,
        input  busy,
        input  done,
        input  done_id,
        input  early,
        input  svc_count
    );

    modport slave (
        input  req,
        input  valid,
        input  grant,
        output gnt_onehot,
        output owner,
        output busy,
        output done,
        output done_id,
        output early,
        output svc_count
    );
endinterface

// File: rtl/grant_tenure_sequencer.sv
// ---------------------------------------------------------------------------
// grant_tenure_sequencer
//   Downstream stage of the priority arbiter. Locks the arbiter's winning
//   channel and holds its one-hot grant for at most HOLD_CYCLES cycles. The
//   tenure ends early if the owner drops its request. Every tenure ends with
//   a single RELEASE cycle (done pulse) followed by at least one IDLE cycle so
//   the arbiter can re-evaluate. A saturating service count per channel is
//   kept for the display.
//
//   Ports
//     clk   in  system clock, all state on the rising edge
//     rst   in  asynchronous, active-high reset
//     bus   grant_tenure_sequencer_if.slave
//             req/valid/grant in; gnt_onehot, owner, busy, done, done_id,
//             early, svc_count out (all registered)
//
//   Parameters
//     N            number of requesters
//     W            grant index width
//     HOLD_CYCLES  maximum tenure in cycles (>= 1)
//     CW           width of each per-channel service counter
// ---------------------------------------------------------------------------
module grant_tenure_sequencer #(
    parameter int N           = 8,
    parameter int W           = (N > 1) ? $clog2(N) : 1,
    parameter int HOLD_CYCLES = 16,
    parameter int CW          = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    grant_tenure_sequencer_if.slave bus
);

    // Tenure counter only has to reach HOLD_CYCLES-1, so it never wraps.
    localparam int                CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]     SVC_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cut_short;

    logic [N-1:0]     gnt_onehot_q, gnt_onehot_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W-1:0]     done_id_q, done_id_d;
    logic             early_q, early_d;
    logic [CW-1:0]    svc_q [N];
    logic [CW-1:0]    svc_d [N];

    logic             grant_in_range;
    logic             req_at_grant;
    logic             req_at_owner;

    // When N is a power of two every grant encoding is a real channel, so the
    // range check collapses to a constant instead of a comparison that lint
    // would flag as always true.
    generate
        if (N == (1 << W)) begin : g_full_range
            assign grant_in_range = 1'b1;
        end else begin : g_partial_range
            assign grant_in_range = ({1'b0, bus.grant} < (W + 1)'(N));
        end
    endgenerate

    assign req_at_grant = grant_in_range && bus.req[bus.grant];
    assign req_at_owner = bus.req[owner_q];

    // State register: FSM state, locked owner and tenure counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. In SERVE a request drop is checked before expiry so
    // that a drop in the final tenure cycle is still reported as early.
    // valid/grant are only looked at in IDLE, so there is no preemption.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        cut_short = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid && req_at_grant) begin
                    owner_d = bus.grant;
                    cnt_d   = '0;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (!req_at_owner) begin
                    cut_short = 1'b1;
                    state_d   = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic. Outputs are computed from the upcoming state so that,
    // once registered, they line up with the state they describe and no
    // input reaches an output without passing through a flop.
    always_comb begin
        gnt_onehot_d = '0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        done_id_d    = '0;
        early_d      = 1'b0;
        case (state_d)
            SERVE: begin
                gnt_onehot_d = N'(1) << owner_d;
                busy_d       = 1'b1;
            end
            RELEASE: begin
                busy_d    = 1'b1;
                done_d    = 1'b1;
                done_id_d = owner_d;
                early_d   = cut_short;
            end
            default: begin
                gnt_onehot_d = '0;
            end
        endcase
    end

    // Service counters advance while leaving RELEASE, so the new value is
    // visible in the cycle after the done pulse. They stick at all-ones.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            svc_d[i] = svc_q[i];
            if ((state_q == RELEASE) && (owner_q == W'(i)) && (svc_q[i] != SVC_MAX)) begin
                svc_d[i] = svc_q[i] + 1'b1;
            end
        end
    end

    // Output and service-count registers. Reset clears everything at once,
    // which drops a grant mid-tenure without producing a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_onehot_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_id_q    <= '0;
            early_q      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                svc_q[i] <= '0;
            end
        end else begin
            gnt_onehot_q <= gnt_onehot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            done_id_q    <= done_id_d;
            early_q      <= early_d;
            for (int i = 0; i < N; i++) begin
                svc_q[i] <= svc_d[i];
            end
        end
    end

    assign bus.gnt_onehot = gnt_onehot_q;
    assign bus.owner      = owner_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.done_id    = done_id_q;
    assign bus.early      = early_q;

    generate
        for (genvar g = 0; g < N; g++) begin : g_svc_flat
            assign bus.svc_count[g*CW +: CW] = svc_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_grant_tenure_sequencer.sv
// ---------------------------------------------------------------------------
// tb_grant_tenure_sequencer
//   Directed bench for grant_tenure_sequencer. Instance dut_a uses the
//   default parameters (N=8, HOLD_CYCLES=16, CW=8). Instance dut_b uses
//   HOLD_CYCLES=1 and CW=2 to exercise the single-cycle tenure and counter
//   saturation. Inputs are driven and outputs sampled 1 time unit after the
//   rising clock edge.
// ---------------------------------------------------------------------------
module tb_grant_tenure_sequencer;

    logic clk;
    logic rst;
    logic rst_b;

    int vectors;
    int miscompares;

    grant_tenure_sequencer_if #(.N(8), .W(3), .CW(8)) bus_a ();
    grant_tenure_sequencer_if #(.N(8), .W(3), .CW(2)) bus_b ();

    grant_tenure_sequencer #(.N(8), .W(3), .HOLD_CYCLES(16), .CW(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    grant_tenure_sequencer #(.N(8), .W(3), .HOLD_CYCLES(1), .CW(2)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the arbiter-side inputs of dut_a.
    task automatic applyStimulus(input logic [7:0] r, input logic v, input logic [2:0] g);
        bus_a.req   = r;
        bus_a.valid = v;
        bus_a.grant = g;
    endtask

    // Drive the arbiter-side inputs of dut_b.
    task automatic applyStimulusB(input logic [7:0] r, input logic v, input logic [2:0] g);
        bus_b.req   = r;
        bus_b.valid = v;
        bus_b.grant = g;
    endtask

    // One comparison: count it, and on mismatch count and report it.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Structural invariants on dut_a, checked mid-cycle on every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("inv_onehot0", 64'($onehot0(bus_a.gnt_onehot)), 64'd1);
            checkOutput("inv_gnt_busy",
                        64'((bus_a.gnt_onehot == 8'h00) || bus_a.busy), 64'd1);
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        rst_b       = 1'b1;
        applyStimulus(8'h00, 1'b0, 3'd0);
        applyStimulusB(8'h00, 1'b0, 3'd0);
        tick();

        // Reset state
        checkOutput("rst_gnt",     64'(bus_a.gnt_onehot), 64'h00);
        checkOutput("rst_owner",   64'(bus_a.owner),      64'd0);
        checkOutput("rst_busy",    64'(bus_a.busy),       64'd0);
        checkOutput("rst_done",    64'(bus_a.done),       64'd0);
        checkOutput("rst_done_id", 64'(bus_a.done_id),    64'd0);
        checkOutput("rst_early",   64'(bus_a.early),      64'd0);
        checkOutput("rst_svc",     64'(bus_a.svc_count),  64'd0);
        rst   = 1'b0;
        rst_b = 1'b0;
        tick();

        // Test 1: full tenure of ch2
        applyStimulus(8'h04, 1'b1, 3'd2);
        tick();
        checkOutput("t1_owner", 64'(bus_a.owner), 64'd2);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("t1_gnt_c%0d", i), 64'(bus_a.gnt_onehot), 64'h04);
            checkOutput($sformatf("t1_done_c%0d", i), 64'(bus_a.done), 64'd0);
            tick();
        end
        checkOutput("t1_rel_gnt",     64'(bus_a.gnt_onehot), 64'h00);
        checkOutput("t1_rel_busy",    64'(bus_a.busy),       64'd1);
        checkOutput("t1_rel_done",    64'(bus_a.done),       64'd1);
        checkOutput("t1_rel_done_id", 64'(bus_a.done_id),    64'd2);
        checkOutput("t1_rel_early",   64'(bus_a.early),      64'd0);
        checkOutput("t1_rel_svc2",    64'(bus_a.svc_count[16 +: 8]), 64'd0);
        tick();
        checkOutput("t1_gap_gnt",  64'(bus_a.gnt_onehot), 64'h00);
        checkOutput("t1_gap_busy", 64'(bus_a.busy),       64'd0);
        checkOutput("t1_gap_done", 64'(bus_a.done),       64'd0);
        checkOutput("t1_svc2",     64'(bus_a.svc_count[16 +: 8]), 64'd1);
        checkOutput("t1_owner_hold", 64'(bus_a.owner),    64'd2);
        tick();
        checkOutput("t1_regrant", 64'(bus_a.gnt_onehot), 64'h04);
        applyStimulus(8'h00, 1'b0, 3'd0);
        tick();
        checkOutput("t1b_done",  64'(bus_a.done),  64'd1);
        checkOutput("t1b_early", 64'(bus_a.early), 64'd1);
        tick();
        checkOutput("t1b_svc2",  64'(bus_a.svc_count[16 +: 8]), 64'd2);
        checkOutput("t1b_early_idle", 64'(bus_a.early), 64'd0);

        // Test 2: ch5 drops its request in the 4th SERVE cycle
        applyStimulus(8'h20, 1'b1, 3'd5);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t2_gnt_c%0d", i), 64'(bus_a.gnt_onehot), 64'h20);
            if (i == 3) applyStimulus(8'h00, 1'b0, 3'd0);
            tick();
        end
        checkOutput("t2_rel_gnt",     64'(bus_a.gnt_onehot), 64'h00);
        checkOutput("t2_rel_done",    64'(bus_a.done),       64'd1);
        checkOutput("t2_rel_done_id", 64'(bus_a.done_id),    64'd5);
        checkOutput("t2_rel_early",   64'(bus_a.early),      64'd1);
        tick();
        checkOutput("t2_svc5", 64'(bus_a.svc_count[40 +: 8]), 64'd1);

        // Test 3: no preemption while ch3 is served
        applyStimulus(8'h08, 1'b1, 3'd3);
        tick();
        applyStimulus(8'h48, 1'b1, 3'd6);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("t3_gnt_c%0d", i), 64'(bus_a.gnt_onehot), 64'h08);
            tick();
        end
        checkOutput("t3_rel_done_id", 64'(bus_a.done_id), 64'd3);
        checkOutput("t3_rel_early",   64'(bus_a.early),   64'd0);
        tick();
        checkOutput("t3_gap_gnt", 64'(bus_a.gnt_onehot), 64'h00);
        tick();
        checkOutput("t3_next_gnt",   64'(bus_a.gnt_onehot), 64'h40);
        checkOutput("t3_next_owner", 64'(bus_a.owner),      64'd6);
        applyStimulus(8'h00, 1'b0, 3'd0);
        tick();
        checkOutput("t3_rel2_done_id", 64'(bus_a.done_id), 64'd6);
        tick();
        checkOutput("t3_svc3", 64'(bus_a.svc_count[24 +: 8]), 64'd1);
        checkOutput("t3_svc6", 64'(bus_a.svc_count[48 +: 8]), 64'd1);

        // Test 4: winner without a request is ignored
        applyStimulus(8'hEF, 1'b1, 3'd4);
        tick();
        tick();
        checkOutput("t4_gnt",  64'(bus_a.gnt_onehot), 64'h00);
        checkOutput("t4_busy", 64'(bus_a.busy),       64'd0);
        checkOutput("t4_owner", 64'(bus_a.owner),     64'd6);
        applyStimulus(8'h00, 1'b0, 3'd0);

        // Test 5: HOLD_CYCLES=1, CW=2 counter saturation on ch0
        applyStimulusB(8'h01, 1'b1, 3'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("t5_serve_gnt_%0d", k), 64'(bus_b.gnt_onehot), 64'h01);
            tick();
            checkOutput($sformatf("t5_rel_gnt_%0d", k),   64'(bus_b.gnt_onehot), 64'h00);
            checkOutput($sformatf("t5_rel_done_%0d", k),  64'(bus_b.done),       64'd1);
            checkOutput($sformatf("t5_rel_early_%0d", k), 64'(bus_b.early),      64'd0);
            tick();
            checkOutput($sformatf("t5_svc0_%0d", k), 64'(bus_b.svc_count[0 +: 2]),
                        (k < 3) ? 64'(k + 1) : 64'd3);
        end
        applyStimulusB(8'h00, 1'b0, 3'd0);

        // Test 6: async reset in the 7th cycle of a tenure
        applyStimulus(8'h02, 1'b1, 3'd1);
        tick();
        for (int i = 0; i < 6; i++) tick();
        checkOutput("t6_pre_gnt", 64'(bus_a.gnt_onehot), 64'h02);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_gnt",   64'(bus_a.gnt_onehot), 64'h00);
        checkOutput("t6_rst_busy",  64'(bus_a.busy),       64'd0);
        checkOutput("t6_rst_done",  64'(bus_a.done),       64'd0);
        checkOutput("t6_rst_owner", 64'(bus_a.owner),      64'd0);
        checkOutput("t6_rst_svc",   64'(bus_a.svc_count),  64'd0);
        tick();
        checkOutput("t6_rst_hold_done", 64'(bus_a.done), 64'd0);
        rst = 1'b0;
        tick();
        checkOutput("t6_after_gnt",   64'(bus_a.gnt_onehot), 64'h02);
        checkOutput("t6_after_owner", 64'(bus_a.owner),      64'd1);
        applyStimulus(8'h00, 1'b0, 3'd0);
        tick();
        checkOutput("t6_after_done_id", 64'(bus_a.done_id), 64'd1);
        tick();
        checkOutput("t6_after_svc1", 64'(bus_a.svc_count[8 +: 8]), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
